// File: rtl/mem_lsu.sv
`default_nettype none
// mem_lsu: byte/halfword/word load-store unit in front of a single-port word RAM.
// Sub-word stores are read-modify-write; faulting requests complete without touching memory.
module mem_lsu #(
   parameter int MEM_AW = 12
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WE,
   input  logic [1:0]        REQ_SIZE,
   input  logic              REQ_SIGNED,
   input  logic [31:0]       REQ_ADDR,
   input  logic [31:0]       REQ_WDATA,
   output logic              RSP_VALID,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_FAULT,
   output logic [MEM_AW-1:0] MEM_A,
   output logic [31:0]       MEM_WD,
   output logic              MEM_WE,
   input  logic [31:0]       MEM_RD
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] c_SZ_BYTE = 2'b00;
   localparam logic [1:0] c_SZ_HALF = 2'b01;
   localparam logic [1:0] c_SZ_WORD = 2'b10;
   localparam logic [1:0] c_SZ_ILL  = 2'b11;

   state_t              r_state;
   logic                r_ready;
   logic                r_rsp_valid;
   logic                r_rsp_fault;
   logic                r_mem_we;
   logic [MEM_AW-1:0]   r_mem_a;
   logic                r_we;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [1:0]          r_off;
   logic [31:0]         r_wdata;
   logic [31:0]         r_word;

   logic [29:0]         w_widx;
   logic                w_oor;
   logic                w_fault;

   // Extract the addressed lane of a word and extend it to 32 bits.
   function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         c_SZ_BYTE: f_load = {{24{sgn & b[7]}}, b};
         c_SZ_HALF: f_load = {{16{sgn & h[15]}}, h};
         default:   f_load = word;
      endcase
   endfunction

   // Replace only the addressed lane(s) of a word with right-aligned store data.
   function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic [31:0] wdata);
      logic [31:0] mask;
      logic [31:0] data;
      case (size)
         c_SZ_BYTE: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {24'd0, wdata[7:0]} << {off, 3'b000};
         end
         c_SZ_HALF: begin
            mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            data = {wdata[15:0], wdata[15:0]};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = wdata;
         end
      endcase
      f_merge = (word & ~mask) | (data & mask);
   endfunction

   assign w_widx  = REQ_ADDR[31:2];
   assign w_oor   = (w_widx >> MEM_AW) != 30'd0;
   assign w_fault = (REQ_SIZE == c_SZ_ILL)
                  | ((REQ_SIZE == c_SZ_HALF) & REQ_ADDR[0])
                  | ((REQ_SIZE == c_SZ_WORD) & (REQ_ADDR[1:0] != 2'b00))
                  | w_oor;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_fault <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_a     <= '0;
         r_we        <= 1'b0;
         r_size      <= 2'b00;
         r_signed    <= 1'b0;
         r_off       <= 2'b00;
         r_wdata     <= 32'd0;
         r_word      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (REQ_VALID) begin
                  r_we     <= REQ_WE;
                  r_size   <= REQ_SIZE;
                  r_signed <= REQ_SIGNED;
                  r_off    <= REQ_ADDR[1:0];
                  r_wdata  <= REQ_WDATA;
                  r_mem_a  <= REQ_ADDR[MEM_AW+1:2];
                  r_ready  <= 1'b0;
                  if (w_fault) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_fault <= 1'b1;
                  end else if (!REQ_WE || (REQ_SIZE != c_SZ_WORD)) begin
                     r_state <= S_READ;
                  end else begin
                     r_state  <= S_WRITE;
                     r_mem_we <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_word <= MEM_RD;
               if (r_we) begin
                  r_state  <= S_WRITE;
                  r_mem_we <= 1'b1;
               end else begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
               end
            end
            S_WRITE: begin
               r_mem_we    <= 1'b0;
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_rsp_fault <= 1'b0;
               r_ready     <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // Data paths are decoded from registered state only, so they are zero outside their window.
   assign REQ_READY = r_ready;
   assign RSP_VALID = r_rsp_valid;
   assign RSP_FAULT = r_rsp_fault;
   assign RSP_RDATA = (r_rsp_valid && !r_rsp_fault && !r_we)
                      ? f_load(r_word, r_size, r_signed, r_off) : 32'd0;
   assign MEM_WE    = r_mem_we;
   assign MEM_A     = r_mem_a;
   assign MEM_WD    = r_mem_we ? f_merge(r_word, r_size, r_off, r_wdata) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// tb_mem_lsu: table-driven requests against a behavioural word RAM, responses checked via a queue.
module tb_mem_lsu;

   logic        CLK, RST_N;
   logic        REQ_VALID, REQ_READY, REQ_WE, REQ_SIGNED;
   logic [1:0]  REQ_SIZE;
   logic [31:0] REQ_ADDR, REQ_WDATA;
   logic        RSP_VALID, RSP_FAULT;
   logic [31:0] RSP_RDATA;
   logic [11:0] MEM_A;
   logic [31:0] MEM_WD, MEM_RD;
   logic        MEM_WE;

   mem_lsu #(.MEM_AW(12)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
      .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
      .RSP_FAULT(RSP_FAULT), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE),
      .MEM_RD(MEM_RD)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          nwe;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } exp_t;

   logic [31:0] mem [0:4095];
   exp_t        sb[$];
   vec_t        vecs [0:22];
   vec_t        b2b [0:5];
   int          total = 0;
   int          bad = 0;
   int          we_cnt = 0;
   logic [11:0] last_wa = '0;
   logic [31:0] last_wd = '0;
   int          mon_lat = 0;
   logic        prev_ready = 1'b1;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign MEM_RD = mem[MEM_A];

   always @(posedge CLK) begin
      if (MEM_WE) begin
         mem[MEM_A] <= MEM_WD;
         we_cnt++;
         last_wa = MEM_A;
         last_wd = MEM_WD;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every RSP_VALID and checks latency since accept.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (prev_ready && !REQ_READY) mon_lat = 1;
         else if (!REQ_READY) mon_lat++;
         if (RSP_VALID) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_rdata", RSP_RDATA, e.rdata);
               chk("rsp_fault", {31'd0, RSP_FAULT}, {31'd0, e.fault});
               chk("rsp_latency", 32'(mon_lat), 32'(e.lat));
            end
         end else begin
            chk("idle_rsp_outputs", {RSP_FAULT, RSP_RDATA[30:0]} | {31'd0, RSP_RDATA[31]}, 32'd0);
         end
      end
      prev_ready = REQ_READY;
   end

   // Called at a negedge with REQ_READY high; returns at the negedge where REQ_READY is high again.
   task automatic do_req(input vec_t v, input bit keep);
      int n;
      int we0;
      REQ_WE     = v.we;
      REQ_SIZE   = v.size;
      REQ_SIGNED = v.sgn;
      REQ_ADDR   = v.addr;
      REQ_WDATA  = v.wdata;
      REQ_VALID  = 1'b1;
      n = 0;
      while (!REQ_READY && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_at_issue", {31'd0, REQ_READY}, 32'd1);
      sb.push_back('{v.rdata, v.fault, v.lat});
      we0 = we_cnt;
      @(posedge CLK);
      n = 0;
      forever begin
         @(negedge CLK);
         if (REQ_READY) break;
         n++;
         if (n > 20) break;
      end
      chk("ready_low_cycles", 32'(n), 32'(v.lat));
      chk("mem_we_pulses", 32'(we_cnt - we0), 32'(v.nwe));
      if (!keep) REQ_VALID = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, REQ_READY}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, RSP_VALID}, 32'd0);
      chk({tag, "_rsp_fault"}, {31'd0, RSP_FAULT}, 32'd0);
      chk({tag, "_rsp_rdata"}, RSP_RDATA, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, MEM_WE}, 32'd0);
      chk({tag, "_mem_a"}, {20'd0, MEM_A}, 32'd0);
      chk({tag, "_mem_wd"}, MEM_WD, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int we0;
      // we, size, sgn, addr, wdata, rdata, fault, lat, nwe
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
      vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0, 2, 1};
      vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h13,   32'h0000005A, 32'h0,        1'b0, 3, 1};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h5A223344, 1'b0, 2, 0};
      vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h20,   32'h0000F080, 32'h0,        1'b0, 2, 1};
      vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h21,   32'h0,        32'hFFFFFFF0, 1'b0, 2, 0};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h20,   32'h0,        32'h00000080, 1'b0, 2, 0};
      vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h20,   32'h0,        32'hFFFFF080, 1'b0, 2, 0};
      vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h00005A22, 1'b0, 2, 0};
      vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h22,   32'hABCD1234, 32'h0,        1'b0, 3, 1};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h1234F080, 1'b0, 2, 0};
      vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h23,   32'h0,        32'h00000012, 1'b0, 2, 0};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h21,   32'h0,        32'h0,        1'b1, 1, 0};
      vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h22,   32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
      vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h20,   32'h00000000, 32'h0,        1'b1, 1, 0};
      vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h4000, 32'h0,        32'h0,        1'b1, 1, 0};
      vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1};
      vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0};
      vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h1234F080, 1'b0, 2, 0};
      vecs[20] = '{1'b0, 2'b01, 1'b0, 32'h3FFE, 32'h0,        32'h0000CAFE, 1'b0, 2, 0};
      vecs[21] = '{1'b1, 2'b00, 1'b0, 32'h4000, 32'h000000AA, 32'h0,        1'b1, 1, 0};
      vecs[22] = '{1'b0, 2'b00, 1'b0, 32'h3FFF, 32'h0,        32'h000000CA, 1'b0, 2, 0};

      b2b[0] = '{1'b1, 2'b10, 1'b0, 32'h30, 32'h80008001, 32'h0,        1'b0, 2, 1};
      b2b[1] = '{1'b0, 2'b01, 1'b1, 32'h32, 32'h0,        32'hFFFF8000, 1'b0, 2, 0};
      b2b[2] = '{1'b1, 2'b00, 1'b0, 32'h30, 32'h0000007F, 32'h0,        1'b0, 3, 1};
      b2b[3] = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        32'h8000807F, 1'b0, 2, 0};
      b2b[4] = '{1'b0, 2'b10, 1'b0, 32'h31, 32'h0,        32'h0,        1'b1, 1, 0};
      b2b[5] = '{1'b0, 2'b00, 1'b1, 32'h31, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};

      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00; REQ_SIGNED = 1'b0;
      REQ_ADDR = 32'd0; REQ_WDATA = 32'd0;
      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #2 chk_reset_outputs("por");
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 23; i++) begin
         do_req(vecs[i], 1'b0);
         if (i == 0) chk("word_store_mem_a", {20'd0, last_wa}, 32'd4);
         if (i == 3) chk("byte_store_mem_wd", last_wd, 32'h5A223344);
         if (i == 10) chk("half_store_mem_wd", last_wd, 32'h1234F080);
      end

      // Back-to-back with REQ_VALID held high throughout.
      for (int i = 0; i < 6; i++) do_req(b2b[i], i != 5);

      // Reset while a sub-word store sits in READ: no write may reach memory.
      REQ_WE = 1'b1; REQ_SIZE = 2'b00; REQ_SIGNED = 1'b0;
      REQ_ADDR = 32'h20; REQ_WDATA = 32'h000000EE; REQ_VALID = 1'b1;
      we0 = we_cnt;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("mid_rst_we_pulses", 32'(we_cnt - we0), 32'd0);
      chk("mid_rst_mem_word", mem[8], 32'h1234F080);
      do_req('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234F080, 1'b0, 2, 0}, 1'b0);

      repeat (3) @(negedge CLK);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning word-address width driven to the data RAM (depth 2**MEM_AW words).
REQ-002 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port REQ_VALID  input  1  request present.
REQ-005 SHALL have port REQ_READY  output  1  block can accept a request.
REQ-006 SHALL have port REQ_WE  input  1  1=store, 0=load.
REQ-007 SHALL have port REQ_SIZE  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-008 SHALL have port REQ_SIGNED  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port REQ_ADDR  input  32  byte address.
REQ-010 SHALL have port REQ_WDATA  input  32  store data, right-aligned.
REQ-011 SHALL have port RSP_VALID  output  1  one-cycle completion pulse.
REQ-012 SHALL have port RSP_RDATA  output  32  load result, extended.
REQ-013 SHALL have port RSP_FAULT  output  1  misaligned/illegal/out-of-range request.
REQ-014 SHALL have ports MEM_A  output  MEM_AW, MEM_WD  output  32, MEM_WE  output  1, MEM_RD  input  32  to a word RAM with combinational read, synchronous write.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, RESP; REQ_READY=1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with REQ_VALID=1 and REQ_READY=1, latching WE, SIZE, SIGNED, ADDR, WDATA.
REQ-017 SHALL flag fault if SIZE=11, SIZE=01 with ADDR[0]=1, SIZE=10 with ADDR[1:0]!=0, or ADDR[31:2] >= 2**MEM_AW.
REQ-018 SHALL transition IDLE->RESP on a faulting request, never asserting MEM_WE for it.
REQ-019 SHALL transition IDLE->READ for loads and sub-word stores, IDLE->WRITE for word stores.
REQ-020 SHALL in READ capture MEM_RD into an internal word register; loads then go to RESP, stores to WRITE.
REQ-021 SHALL in WRITE assert MEM_WE=1 for exactly one cycle, then go to RESP.
REQ-022 SHALL in RESP assert RSP_VALID=1 for exactly one cycle, then return to IDLE; no response backpressure.
REQ-023 SHALL drive MEM_A = latched ADDR[MEM_AW+1:2] in READ/WRITE/RESP, and MEM_WE=0 outside WRITE.
REQ-024 SHALL use little-endian lanes: byte k = bits [8k+7:8k] selected by ADDR[1:0]=k; halfword at ADDR[1]*16.
REQ-025 SHALL drive MEM_WD in WRITE as captured word with only the addressed lane(s) replaced by REQ_WDATA low bits; full REQ_WDATA for word stores.
REQ-026 SHALL drive RSP_RDATA for loads as selected lane zero-extended (SIGNED=0) or sign-extended (SIGNED=1); word loads unmodified.
REQ-027 SHALL drive RSP_RDATA=0 for stores and faults; RSP_RDATA/RSP_FAULT valid only while RSP_VALID=1, 0 otherwise.
REQ-028 SHALL meet latency from accepting edge to RSP_VALID high: fault 1, load 2, word store 2, sub-word store 3 cycles.
REQ-029 SHALL ignore REQ_* while not in IDLE; a request held through RESP is accepted on the edge after return to IDLE.

Reset
REQ-030 SHALL on RST_N=0, immediately and regardless of clock, force state IDLE, REQ_READY=1, RSP_VALID=0, RSP_FAULT=0, RSP_RDATA=0, MEM_WE=0, MEM_A=0, MEM_WD=0, internal registers 0.
REQ-031 SHALL abandon any in-flight operation on reset; a store reset before WRITE SHALL leave memory unmodified.

Verification
REQ-032 SHALL verify: word store 0xDEADBEEF to 0x10 then word load 0x10 -> MEM_WE one pulse at MEM_A=4; load RSP_RDATA=0xDEADBEEF, latency 2.
REQ-033 SHALL verify: byte store 0x5A to 0x13 over word 0x11223344 -> MEM_WD=0x5A223344, response 3 cycles after accept.
REQ-034 SHALL verify: word 0x0000F080 at 0x20; signed byte load 0x21 -> 0xFFFFFFF0; unsigned byte load 0x20 -> 0x00000080; signed half load 0x20 -> 0xFFFFF080.
REQ-035 SHALL verify: half load at 0x21, word store at 0x22, SIZE=11, address 0x4000 (MEM_AW=12) -> RSP_FAULT=1, RSP_RDATA=0, latency 1, MEM_WE never 1.
REQ-036 SHALL verify: RST_N low during WRITE-pending sub-word store (in READ) -> MEM_WE stays 0, outputs at reset values, target word unchanged.
REQ-037 SHALL verify: REQ_VALID held high continuously -> back-to-back requests, REQ_READY low from accept until return to IDLE.
